wb_ram_slave: RTL and testbench

Wishbone B3 slave controller that fronts the single read/write port of the team's dual-port block RAM, turning bus cycles into RAM address/write-enable/data strobes. RAM has no byte enables, so partial-width writes run as read-modify-write. Sits between the system Wishbone interconnect and the RAM's `clk` port; the RAM's second read-only port stays free for other consumers.

---
 rtl/wb_ram_slave.sv | 108 ++++++++++
 tb/tb_wb_ram_slave.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone B3 slave fronting one block-RAM port; partial writes run as read-modify-write.
// Define WB_RAM_BURST_EN to add incrementing read bursts steered by wb_cti_i.
module wb_ram_slave #(
    parameter int data_width = 32,
    parameter int addr_width = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [addr_width-1:0]   wb_adr_i,
    input  logic [data_width/8-1:0] wb_sel_i,
    input  logic [data_width-1:0]   wb_dat_i,
    input  logic [2:0]              wb_cti_i,
    output logic [data_width-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic [addr_width-1:0]   ram_addr,
    output logic                    ram_we,
    output logic [data_width-1:0]   ram_dat_w,
    input  logic [data_width-1:0]   ram_dat_r
);
    localparam int nb = data_width / 8;
`ifdef WB_RAM_BURST_EN
    typedef enum logic [2:0] {IDLE, RD, RMW, ACK, BURST} state_t;
`else
    typedef enum logic [1:0] {IDLE, RD, RMW, ACK} state_t;
`endif
    state_t                r_state;
    logic [addr_width-1:0] r_addr;
    logic [addr_width-1:0] w_next;
    logic                  w_req;
    logic                  w_full;
    logic                  w_none;
    logic                  w_adv;
    logic [data_width-1:0] w_merge;

    assign w_req  = wb_cyc_i & wb_stb_i;
    assign w_full = &wb_sel_i;
    assign w_none = ~|wb_sel_i;
    assign w_next = r_addr + 1'b1;

    // With all selects set the merge is just wb_dat_i, so one mux serves both write paths.
    for (genvar k = 0; k < nb; k++) begin : g_merge
        assign w_merge[8*k +: 8] = wb_sel_i[k] ? wb_dat_i[8*k +: 8] : ram_dat_r[8*k +: 8];
    end

`ifdef WB_RAM_BURST_EN
    // w_adv: a beat is delivered at the coming edge, so the RAM must fetch the following word now.
    assign w_adv = (r_state == RD) ? (wb_cyc_i && wb_cti_i == 3'b010)
                 : (r_state == BURST) && w_req && !(wb_ack_o && wb_cti_i == 3'b111);
`else
    logic w_unused_cti;
    assign w_unused_cti = ^wb_cti_i;
    assign w_adv        = 1'b0;
`endif

    assign ram_addr  = (r_state == IDLE) ? wb_adr_i : w_adv ? w_next : r_addr;
    assign ram_dat_w = w_merge;
    assign ram_we    = !rst && ((r_state == IDLE && w_req && wb_we_i && w_full) ||
                                (r_state == RMW && wb_cyc_i));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            if (w_adv) r_addr <= w_next;
            case (r_state)
                IDLE: if (w_req) begin
                    r_addr <= wb_adr_i;
                    if (!wb_we_i) r_state <= RD;
                    else if (w_full || w_none) begin
                        wb_ack_o <= 1'b1;
                        r_state  <= ACK;
                    end else r_state <= RMW;
                end
                RD: if (!wb_cyc_i) r_state <= IDLE;
                else begin
                    wb_dat_o <= ram_dat_r;
                    wb_ack_o <= 1'b1;
`ifdef WB_RAM_BURST_EN
                    r_state  <= w_adv ? BURST : ACK;
`else
                    r_state  <= ACK;
`endif
                end
                RMW: if (!wb_cyc_i) r_state <= IDLE;
                else begin
                    wb_ack_o <= 1'b1;
                    r_state  <= ACK;
                end
                ACK: r_state <= IDLE;
`ifdef WB_RAM_BURST_EN
                BURST: if (!wb_cyc_i) r_state <= IDLE;
                else if (w_adv) begin
                    wb_dat_o <= ram_dat_r;
                    wb_ack_o <= 1'b1;
                end else if (wb_stb_i) r_state <= IDLE;
`endif
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_ram_slave.sv
// tb_wb_ram_slave: directed checks of wb_ram_slave against a behavioural block-RAM model.
module tb_wb_ram_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [7:0]  wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [2:0]  wb_cti_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_dat_w;
    logic [31:0] ram_dat_r;

    logic [31:0] mem [0:255];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = '0;
    logic [31:0] bd_dat = '0;

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_dat;
        else if (ram_we) mem[ram_addr] <= ram_dat_w;
        ram_dat_r <= mem[ram_addr];
    end

    wb_ram_slave #(.data_width(32), .addr_width(8)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i), .wb_cti_i(wb_cti_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_dat_w(ram_dat_w), .ram_dat_r(ram_dat_r)
    );

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_dat = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic xfer(input logic we, input logic [7:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, output int lat, output int wes,
                        output logic [31:0] rd, output logic ack_after);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
        lat = 0; wes = 0;
        #1;
        if (ram_we) wes++;
        while (wb_ack_o !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
            if (ram_we) wes++;
        end
        rd = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk);
        ack_after = wb_ack_o;
    endtask

    task automatic test_reset;
        nchk++; if (wb_ack_o !== 1'b0) begin nfail++; $display("FAIL reset_ack: got %b expected 0", wb_ack_o); end
        nchk++; if (wb_dat_o !== 32'h0) begin nfail++; $display("FAIL reset_dat: got %h expected 0", wb_dat_o); end
        nchk++; if (ram_we !== 1'b0) begin nfail++; $display("FAIL reset_we: got %b expected 0", ram_we); end
    endtask

    task automatic test_full_write_read;
        int lat, wes; logic [31:0] rd; logic aa;
        xfer(1'b1, 8'h05, 4'hF, 32'hDEADBEEF, lat, wes, rd, aa);
        nchk++; if (lat !== 1) begin nfail++; $display("FAIL full_wr_lat: got %0d expected 1", lat); end
        nchk++; if (wes !== 1) begin nfail++; $display("FAIL full_wr_we_cycles: got %0d expected 1", wes); end
        nchk++; if (aa !== 1'b0) begin nfail++; $display("FAIL full_wr_ack_pulse: got %b expected 0", aa); end
        nchk++; if (mem[5] !== 32'hDEADBEEF) begin nfail++; $display("FAIL full_wr_mem: got %h expected deadbeef", mem[5]); end
        xfer(1'b0, 8'h05, 4'hF, 32'h0, lat, wes, rd, aa);
        nchk++; if (lat !== 2) begin nfail++; $display("FAIL rd_lat: got %0d expected 2", lat); end
        nchk++; if (rd !== 32'hDEADBEEF) begin nfail++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
        nchk++; if (wes !== 0) begin nfail++; $display("FAIL rd_we: got %0d expected 0", wes); end
        nchk++; if (aa !== 1'b0) begin nfail++; $display("FAIL rd_ack_pulse: got %b expected 0", aa); end
    endtask

    task automatic test_rmw;
        int lat, wes; logic [31:0] rd; logic aa;
        xfer(1'b1, 8'h07, 4'b0101, 32'hAABBCCDD, lat, wes, rd, aa);
        nchk++; if (lat !== 2) begin nfail++; $display("FAIL rmw_lat: got %0d expected 2", lat); end
        nchk++; if (wes !== 1) begin nfail++; $display("FAIL rmw_we_cycles: got %0d expected 1", wes); end
        nchk++; if (mem[7] !== 32'h11BB33DD) begin nfail++; $display("FAIL rmw_mem: got %h expected 11bb33dd", mem[7]); end
        xfer(1'b0, 8'h07, 4'hF, 32'h0, lat, wes, rd, aa);
        nchk++; if (rd !== 32'h11BB33DD) begin nfail++; $display("FAIL rmw_readback: got %h expected 11bb33dd", rd); end
    endtask

    task automatic test_abort;
        int lat, wes; logic [31:0] rd; logic aa;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 8'h20; wb_sel_i = 4'hF;
        @(negedge clk);
        nchk++; if (wb_ack_o !== 1'b0) begin nfail++; $display("FAIL abort_rd_ack0: got %b expected 0", wb_ack_o); end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        nchk++; if (wb_ack_o !== 1'b0) begin nfail++; $display("FAIL abort_ack1: got %b expected 0", wb_ack_o); end
        @(negedge clk);
        nchk++; if (wb_ack_o !== 1'b0) begin nfail++; $display("FAIL abort_ack2: got %b expected 0", wb_ack_o); end
        nchk++; if (wb_dat_o !== 32'h11BB33DD) begin nfail++; $display("FAIL abort_dat_held: got %h expected 11bb33dd", wb_dat_o); end
        xfer(1'b0, 8'h05, 4'hF, 32'h0, lat, wes, rd, aa);
        nchk++; if (lat !== 2) begin nfail++; $display("FAIL after_abort_lat: got %0d expected 2", lat); end
        nchk++; if (rd !== 32'hDEADBEEF) begin nfail++; $display("FAIL after_abort_data: got %h expected deadbeef", rd); end
    endtask

    task automatic test_sel_zero;
        int lat, wes; logic [31:0] rd; logic aa;
        xfer(1'b1, 8'h30, 4'h0, 32'h01020304, lat, wes, rd, aa);
        nchk++; if (lat !== 1) begin nfail++; $display("FAIL sel0_lat: got %0d expected 1", lat); end
        nchk++; if (wes !== 0) begin nfail++; $display("FAIL sel0_we: got %0d expected 0", wes); end
        nchk++; if (mem[8'h30] !== 32'h55AA55AA) begin nfail++; $display("FAIL sel0_mem: got %h expected 55aa55aa", mem[8'h30]); end
    endtask

    task automatic test_reset_mid_rmw;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 8'h10; wb_sel_i = 4'b0011; wb_dat_i = 32'hFFFFFFFF;
        @(negedge clk);
        nchk++; if (ram_we !== 1'b1) begin nfail++; $display("FAIL rmw_we_before_rst: got %b expected 1", ram_we); end
        rst = 1'b1;
        #1;
        nchk++; if (ram_we !== 1'b0) begin nfail++; $display("FAIL rst_rmw_we: got %b expected 0", ram_we); end
        nchk++; if (wb_ack_o !== 1'b0) begin nfail++; $display("FAIL rst_rmw_ack: got %b expected 0", wb_ack_o); end
        nchk++; if (wb_dat_o !== 32'h0) begin nfail++; $display("FAIL rst_rmw_dat: got %h expected 0", wb_dat_o); end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nchk++; if (mem[8'h10] !== 32'hCAFEF00D) begin nfail++; $display("FAIL rst_rmw_mem: got %h expected cafef00d", mem[8'h10]); end
    endtask

`ifdef WB_RAM_BURST_EN
    task automatic test_burst;
        logic [31:0] exp_d;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = 8'hFE; wb_sel_i = 4'hF; wb_cti_i = 3'b010;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            nchk++;
            if (wb_ack_o !== (k >= 1 && k <= 4)) begin
                nfail++; $display("FAIL burst_ack[%0d]: got %b expected %b", k, wb_ack_o, (k >= 1 && k <= 4));
            end
            if (k >= 1 && k <= 4) begin
                exp_d = (k == 1) ? 32'h0F0F00FE : (k == 2) ? 32'h0F0F00FF : (k == 3) ? 32'h0F0F0000 : 32'h0F0F0001;
                nchk++;
                if (wb_dat_o !== exp_d) begin nfail++; $display("FAIL burst_dat[%0d]: got %h expected %h", k, wb_dat_o, exp_d); end
            end
            if (k == 4) wb_cti_i = 3'b111;
            if (k == 5) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = 3'b000; end
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0; wb_cti_i = '0;
        @(negedge clk);
        poke(8'h07, 32'h11223344);
        poke(8'h10, 32'hCAFEF00D);
        poke(8'h20, 32'h12345678);
        poke(8'h30, 32'h55AA55AA);
        poke(8'hFE, 32'h0F0F00FE);
        poke(8'hFF, 32'h0F0F00FF);
        poke(8'h00, 32'h0F0F0000);
        poke(8'h01, 32'h0F0F0001);
        test_reset;
        rst = 1'b0;
        @(negedge clk);
        test_full_write_read;
        test_rmw;
        test_abort;
        test_sel_zero;
        test_reset_mid_rmw;
`ifdef WB_RAM_BURST_EN
        test_burst;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
